// File: rtl/chu_gpi_pkg.sv
// Register map shared by the GPI debounce slot and its software view.
package chu_gpi_pkg;

    localparam logic [4:0] GPI_DB   = 5'd0;
    localparam logic [4:0] GPI_RISE = 5'd1;
    localparam logic [4:0] GPI_FALL = 5'd2;
    localparam logic [4:0] GPI_MASK = 5'd3;
    localparam logic [4:0] GPI_RAW  = 5'd4;

endpackage

// File: rtl/gpi_debounce_cell.sv
// One input bit: 2-flop synchronizer, stability counter, debounced level
// and single-cycle edge strobes.
module gpi_debounce_cell #(
    parameter int unsigned DB_TICKS = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int unsigned    CW   = $clog2(DB_TICKS);
    localparam logic [CW-1:0]  LAST = CW'(DB_TICKS - 1);

    logic          s0;
    logic          s1;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Two-stage synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= din;
            s1 <= s0;
        end
    end

    // Accept a new level only after it has differed from db for DB_TICKS cycles.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (s1 == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            db_d  = s1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debounced level and counter state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    // Strobes are taken from the next-state level so the sticky flags set
    // on the same edge that db changes.
    assign rise = db_d & ~db_q;
    assign fall = ~db_d & db_q;
    assign sync = s1;
    assign db   = db_q;

endmodule

// File: rtl/chu_gpi_debounce.sv
// Debounced general-purpose input slot with sticky edge flags and a
// masked level interrupt on rising edges.
module chu_gpi_debounce
    import chu_gpi_pkg::*;
#(
    parameter int unsigned W        = 4,
    parameter int unsigned DB_TICKS = 500000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [W-1:0] din,
    output logic         irq
);

    logic [W-1:0] sync;
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] rise_flag;
    logic [W-1:0] fall_flag;
    logic [W-1:0] mask;
    logic [W-1:0] clr_rise;
    logic [W-1:0] clr_fall;
    logic         wr_en;
    logic         unused_ok;

    assign unused_ok = &{1'b0, read, wr_data};

    for (genvar g = 0; g < W; g++) begin : g_cell
        gpi_debounce_cell #(
            .DB_TICKS(DB_TICKS)
        ) u_cell (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (din[g]),
            .sync   (sync[g]),
            .db     (db[g]),
            .rise   (rise[g]),
            .fall   (fall[g])
        );
    end

    assign wr_en    = cs & write;
    assign clr_rise = (wr_en && addr == GPI_RISE) ? wr_data[W-1:0] : '0;
    assign clr_fall = (wr_en && addr == GPI_FALL) ? wr_data[W-1:0] : '0;

    // Sticky flags (set beats clear) and interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_flag <= '0;
            fall_flag <= '0;
            mask      <= '0;
        end else begin
            rise_flag <= (rise_flag & ~clr_rise) | rise;
            fall_flag <= (fall_flag & ~clr_fall) | fall;
            if (wr_en && addr == GPI_MASK) begin
                mask <= wr_data[W-1:0];
            end
        end
    end

    // Combinational register read mux, zero-extended.
    always_comb begin
        rd_data = '0;
        case (addr)
            GPI_DB:   rd_data[W-1:0] = db;
            GPI_RISE: rd_data[W-1:0] = rise_flag;
            GPI_FALL: rd_data[W-1:0] = fall_flag;
            GPI_MASK: rd_data[W-1:0] = mask;
            GPI_RAW:  rd_data[W-1:0] = sync;
            default:  rd_data = '0;
        endcase
    end

    assign irq = |(rise_flag & mask);

endmodule

// File: tb/tb_chu_gpi_debounce.sv
// Self-checking bench for chu_gpi_debounce (W=4, DB_TICKS=4).
module tb_chu_gpi_debounce;

    localparam int unsigned W  = 4;
    localparam int unsigned DB = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [W-1:0] din;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    chu_gpi_debounce #(
        .W       (W),
        .DB_TICKS(DB)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .cs     (cs),
        .read   (read),
        .write  (write),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .din    (din),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Reference model: din samples per edge; a level is accepted when the
    // synchronized value (din two edges earlier) has differed from db for
    // DB consecutive edges.
    logic [W-1:0] hist [$];
    logic [W-1:0] m_db, m_rf, m_ff, m_mask;

    function automatic logic [W-1:0] m_sync();
        if (hist.size() < 2) return '0;
        return hist[hist.size()-2];
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            5'd0: r[W-1:0] = m_db;
            5'd1: r[W-1:0] = m_rf;
            5'd2: r[W-1:0] = m_ff;
            5'd3: r[W-1:0] = m_mask;
            5'd4: r[W-1:0] = m_sync();
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        m_db = '0; m_rf = '0; m_ff = '0; m_mask = '0;
    endtask

    // One clock edge: advance the model from the inputs the DUT samples,
    // then compare the current read port and irq.
    task automatic step();
        logic [W-1:0] nd, rs, fl, cr, cf;
        int L;
        bit all_diff;
        hist.push_back(din);
        L  = hist.size() - 1;
        nd = m_db;
        if (hist.size() >= DB + 2) begin
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                for (int k = 2; k < DB + 2; k++)
                    if (hist[L-k][i] == m_db[i]) all_diff = 1'b0;
                if (all_diff) nd[i] = ~m_db[i];
            end
        end
        rs = nd & ~m_db;
        fl = ~nd & m_db;
        cr = (cs && write && addr == 5'd1) ? wr_data[W-1:0] : '0;
        cf = (cs && write && addr == 5'd2) ? wr_data[W-1:0] : '0;
        if (cs && write && addr == 5'd3) m_mask = wr_data[W-1:0];
        m_rf = (m_rf & ~cr) | rs;
        m_ff = (m_ff & ~cf) | fl;
        m_db = nd;
        if (hist.size() > 16) void'(hist.pop_front());
        @(posedge clk);
        #1;
        chk("model_rd", rd_data, exp_rd(addr));
        chk("model_irq", {31'b0, irq}, {31'b0, |(m_rf & m_mask)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cs = 1'b0; write = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic rd_at(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    task automatic wr_step(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        step();
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; wr_data = '0; din = '0;
        model_clear();

        vecs[0] = '{1'b0, 5'd0, 32'h0,         5'd0,  32'h0};
        vecs[1] = '{1'b1, 5'd3, 32'hFFFF_FFF5, 5'd3,  32'h5};
        vecs[2] = '{1'b1, 5'd7, 32'hFFFF_FFFF, 5'd3,  32'h5};
        vecs[3] = '{1'b1, 5'd7, 32'hFFFF_FFFF, 5'd1,  32'h0};
        vecs[4] = '{1'b0, 5'd0, 32'h0,         5'd5,  32'h0};
        vecs[5] = '{1'b0, 5'd0, 32'h0,         5'd31, 32'h0};
        vecs[6] = '{1'b1, 5'd3, 32'h0000_000A, 5'd3,  32'hA};
        vecs[7] = '{1'b1, 5'd3, 32'h0,         5'd3,  32'h0};

        // Reset state.
        @(negedge clk);
        for (int a = 0; a < 5; a++) rd_at("reset_rd", 5'(a), 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        do_reset();

        // Register access table with din idle.
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].we) wr_step(vecs[v].waddr, vecs[v].wdata);
            else step();
            rd_at("table_rd", vecs[v].raddr, vecs[v].exp_rd);
        end

        // Held level reaches db on the sixth edge, not earlier.
        do_reset();
        din = 4'b0001; addr = 5'd0;
        for (int c = 1; c <= 6; c++) begin
            step();
            rd_at("db_latency", 5'd0, (c == 6) ? 32'h1 : 32'h0);
        end
        rd_at("rise_after_db", 5'd1, 32'h1);
        chk("irq_unmasked", {31'b0, irq}, 32'h0);

        // Three-cycle glitch on bit 1 is rejected.
        do_reset();
        din = 4'b0010; addr = 5'd4;
        step();
        step();
        rd_at("raw_pulse", 5'd4, 32'h2);
        step();
        din = 4'b0000;
        for (int c = 0; c < 8; c++) step();
        rd_at("glitch_db", 5'd0, 32'h0);
        rd_at("glitch_rise", 5'd1, 32'h0);

        // Masked interrupt follows the db edge and software clear.
        do_reset();
        wr_step(5'd3, 32'h1);
        din = 4'b0001; addr = 5'd0;
        for (int c = 1; c <= 6; c++) begin
            step();
            chk("irq_edge", {31'b0, irq}, (c == 6) ? 32'h1 : 32'h0);
        end
        wr_step(5'd1, 32'h1);
        rd_at("rise_cleared", 5'd1, 32'h0);
        chk("irq_cleared", {31'b0, irq}, 32'h0);

        // Clear on the same edge as the set: set wins.
        do_reset();
        din = 4'b0001;
        for (int c = 1; c <= 5; c++) step();
        wr_step(5'd1, 32'h1);
        rd_at("set_wins", 5'd1, 32'h1);

        // Falling edges, then reset mid-count, then recount from scratch.
        do_reset();
        din = 4'b1111;
        for (int c = 0; c < 8; c++) step();
        rd_at("db_all_high", 5'd0, 32'hF);
        din = 4'b0000;
        for (int c = 1; c <= 6; c++) begin
            step();
            rd_at("fall_flag", 5'd2, (c == 6) ? 32'hF : 32'h0);
        end
        din = 4'b1111;
        for (int c = 0; c < 3; c++) step();
        @(negedge clk);
        reset_n = 1'b0;
        model_clear();
        for (int a = 0; a < 5; a++) rd_at("midreset_rd", 5'(a), 32'h0);
        chk("midreset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            rd_at("recount_db", 5'd0, (c == 6) ? 32'hF : 32'h0);
        end
        rd_at("recount_rise", 5'd1, 32'hF);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 5) == 0) din[i] = ~din[i];
            cs      = ($urandom_range(0, 3) != 0);
            write   = ($urandom_range(0, 4) == 0);
            read    = $urandom_range(0, 1) != 0;
            addr    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
            wr_data = $urandom;
            step();
        end
        cs = 1'b0; write = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chu_gpi_debounce.md
CHU_GPI_DEBOUNCE -- requirements
Module: chu_gpi_debounce

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- W, 4, width of the input port.
- DB_TICKS, 500000, stable cycles needed to accept a level change; minimum 2.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- reset_n, in, 1, asynchronous active-low reset.
- cs, in, 1, slot select.
- read, in, 1, slot read strobe; ignored, reads have no side effect.
- write, in, 1, slot write strobe.
- addr, in, 5, slot word address.
- wr_data, in, 32, slot write data.
- rd_data, out, 32, slot read data.
- din, in, W, external asynchronous inputs (switches/buttons).
- irq, out, 1, level interrupt.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset_n.

Function
REQ-004 Each din bit SHALL pass through a 2-flop synchronizer (sync) before any other use.
REQ-005 Each bit SHALL hold a debounced level db[i] and a counter of width $clog2(DB_TICKS).
REQ-006 Counter rule, per bit, per cycle:
- if sync[i]==db[i], the counter SHALL clear to 0;
- else if the counter equals DB_TICKS-1, db[i] SHALL take sync[i] and the counter SHALL clear;
- otherwise the counter SHALL increment.
REQ-007 A held din change SHALL appear on db exactly 2+DB_TICKS rising edges after it is sampled. A sync pulse shorter than DB_TICKS cycles SHALL leave db unchanged.
REQ-008 rise[i] SHALL pulse for one cycle on the edge where db[i] goes 0->1. fall[i] SHALL pulse for one cycle on the edge where db[i] goes 1->0.
REQ-009 The sticky registers rise_flag and fall_flag SHALL set on their pulse and hold until cleared by software.
REQ-010 A write (cs && write) SHALL act by address:
- addr 1: clear each rise_flag bit where wr_data is 1;
- addr 2: the same for fall_flag;
- addr 3: load mask <= wr_data[W-1:0];
- any other address: no effect.
REQ-011 If a set and a clear hit the same flag bit in the same cycle, the set SHALL win.
REQ-012 rd_data SHALL be combinational from addr, zero-extended to 32 bits:
- addr 0: db;
- addr 1: rise_flag;
- addr 2: fall_flag;
- addr 3: mask;
- addr 4: sync;
- any other address: 0.
REQ-013 irq SHALL equal |(rise_flag & mask) with no register stage, so it rises on the same edge as the flag it depends on.
REQ-014 Writes SHALL NOT disturb the debounce counters or db.

Reset
REQ-015 While reset_n=0, the following SHALL be 0: sync flops, db, counters, rise_flag, fall_flag, mask. irq SHALL therefore be 0.
REQ-016 Reset asserted during a debounce count SHALL abandon the count. After release, a din held at 1 SHALL need a full 2+DB_TICKS cycles to reach db, and SHALL then set rise_flag.

Structure
REQ-017 A package chu_gpi_pkg SHALL hold the register address constants GPI_DB=0, GPI_RISE=1, GPI_FALL=2, GPI_MASK=3, GPI_RAW=4.
REQ-018 Per-bit synchronizer, counter and edge detection SHALL live in one sub-module, gpi_debounce_cell, with parameter DB_TICKS and outputs db, rise, fall. The top SHALL instantiate it W times in a generate loop.
REQ-019 The implementation SHALL NOT use latches or derived clocks.

Verification
All scenarios use W=4, DB_TICKS=4.
REQ-020 din=4'b0001 held from cycle 0 -> db reads 1 at addr 0 on cycle 6 and not before; rise_flag=4'b0001; irq stays 0 while mask=0.
REQ-021 Glitch: din[1]=1 for 3 cycles, then 0 -> db[1] stays 0; rise_flag[1] stays 0; addr 4 shows the raw pulse.
REQ-022 Write mask=4'b0001, then debounce din[0] to 1 -> irq=1 on the db edge. Write 32'h1 to addr 1 -> rise_flag=0 and irq=0 the next cycle.
REQ-023 Clear rise_flag[0] on the same edge that db[0] rises -> rise_flag[0]=1 remains (set wins).
REQ-024 Debounce din=4'b1111, then return din to 0 -> fall_flag=4'b1111 at cycle 6 after the change. Then assert reset_n=0 mid-count -> all reads return 0 and irq=0.
REQ-025 Read addr 5..31 -> rd_data=0. Write addr 7 -> no register changes.
